// File: rtl/ol_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ol_pkg
//  Brief   : Shared link constants, packet framer state encoding and helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package ol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } ol_state_e;

    localparam logic [15:0] c_IDLE_WORD    = 16'h50BC;
    localparam logic [3:0]  c_HDR_TAG      = 4'hA;
    localparam logic [1:0]  c_K_IDLE       = 2'b01;
    localparam logic [1:0]  c_K_DATA       = 2'b00;
    localparam logic [15:0] c_TRAILER_WORD = 16'hFFFF;
    localparam int          c_IDX_W        = 3;

    function automatic logic [15:0] ol_hdr_word(
        input logic [3:0]  tag,
        input logic [2:0]  src,
        input logic [7:0]  len
    );
        return {tag, 1'b0, src, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ol_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : ol_rr_pick
//  Brief   : Combinational round-robin pick, first set request above the
//            previous winner (with wrap).
//  Rev     : 1.0  initial release
// ============================================================================
module ol_rr_pick
    import ol_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [c_IDX_W-1:0] i_last_winner,
    output logic [c_IDX_W-1:0] o_winner,
    output logic               o_valid
);

    int w_idx;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = int'(i_last_winner) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (i_req[w_idx]) begin
                o_winner = c_IDX_W'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ol_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : ol_tx_arbiter
//  Brief   : Round-robin packet framer onto the link (header/payload/trailer).
//            OL_TX_ARB_CHECKSUM_EN: trailer carries XOR of header and payload.
//  Rev     : 1.0  initial release
// ============================================================================
module ol_tx_arbiter
    import ol_pkg::*;
#(
    parameter int          NREQ      = 4,
    parameter logic [15:0] IDLE_WORD = c_IDLE_WORD,
    parameter logic [3:0]  HDR_TAG   = c_HDR_TAG
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               link_ready,
    input  logic [NREQ-1:0]    req,
    input  logic [8*NREQ-1:0]  req_len,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    rd,
    output logic [15:0]        tx_data,
    output logic [1:0]         tx_datak,
    output logic               busy
);

    ol_state_e            r_state;
    ol_state_e            w_next;
    logic [NREQ-1:0]      r_grant,   w_grant_nx;
    logic [NREQ-1:0]      r_rd,      w_rd_nx;
    logic [15:0]          r_tx_data, w_tx_data_nx;
    logic [1:0]           r_tx_datak, w_datak_nx;
    logic                 r_busy;
    logic [c_IDX_W-1:0]   r_last_winner, w_last_nx;
    logic [7:0]           r_len_cnt, w_len_nx;
    logic [7:0]           w_len_dec;
    logic [c_IDX_W-1:0]   w_win;
    logic                 w_win_valid;
    logic [NREQ-1:0]      w_win_oh;
    logic [7:0]           w_win_len;
    logic [15:0]          w_owner_data;
    logic [15:0]          w_trailer;

    ol_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req         (req),
        .i_last_winner (r_last_winner),
        .o_winner      (w_win),
        .o_valid       (w_win_valid)
    );

    assign w_win_oh     = NREQ'(1) << w_win;
    assign w_win_len    = req_len[w_win*8 +: 8];
    assign w_owner_data = req_data[r_last_winner*16 +: 16];
    assign w_len_dec    = r_len_cnt - 8'd1;

`ifdef OL_TX_ARB_CHECKSUM_EN
    logic [15:0] r_csum, w_csum_nx;

    assign w_trailer = r_csum;

    always_comb begin
        w_csum_nx = '0;
        if (r_state == ST_IDLE && w_next == ST_HEADER) begin
            w_csum_nx = w_tx_data_nx;
        end else if (w_next == ST_PAYLOAD) begin
            w_csum_nx = r_csum ^ w_tx_data_nx;
        end else if (w_next == ST_TRAILER) begin
            w_csum_nx = r_csum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_nx;
        end
    end
`else
    assign w_trailer = c_TRAILER_WORD;
`endif

    // Outputs are computed for the next state and registered. rd is high in
    // the cycle whose closing edge captures the owner's word, so a show-ahead
    // source can pop on that same edge.
    always_comb begin
        w_next       = r_state;
        w_grant_nx   = r_grant;
        w_rd_nx      = '0;
        w_tx_data_nx = IDLE_WORD;
        w_datak_nx   = c_K_IDLE;
        w_last_nx    = r_last_winner;
        w_len_nx     = r_len_cnt;

        case (r_state)
            ST_IDLE: begin
                w_grant_nx = '0;
                if (link_ready && w_win_valid) begin
                    w_next       = ST_HEADER;
                    w_grant_nx   = w_win_oh;
                    w_last_nx    = w_win;
                    w_len_nx     = w_win_len;
                    w_tx_data_nx = ol_hdr_word(HDR_TAG, w_win, w_win_len);
                    w_datak_nx   = c_K_DATA;
                    w_rd_nx      = (w_win_len != 8'd0) ? w_win_oh : '0;
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                w_datak_nx = c_K_DATA;
                if (r_len_cnt != 8'd0) begin
                    w_next       = ST_PAYLOAD;
                    w_tx_data_nx = w_owner_data;
                    w_len_nx     = w_len_dec;
                    w_rd_nx      = (w_len_dec != 8'd0) ? r_grant : '0;
                end else begin
                    w_next       = ST_TRAILER;
                    w_tx_data_nx = w_trailer;
                end
            end
            ST_TRAILER: begin
                w_next     = ST_IDLE;
                w_grant_nx = '0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase

        // Link loss aborts the packet outright; arbitration history is kept.
        if (r_state != ST_IDLE && !link_ready) begin
            w_next       = ST_IDLE;
            w_grant_nx   = '0;
            w_rd_nx      = '0;
            w_tx_data_nx = IDLE_WORD;
            w_datak_nx   = c_K_IDLE;
            w_len_nx     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_rd          <= '0;
            r_tx_data     <= IDLE_WORD;
            r_tx_datak    <= c_K_IDLE;
            r_busy        <= 1'b0;
            r_last_winner <= c_IDX_W'(NREQ - 1);
            r_len_cnt     <= '0;
        end else begin
            r_state       <= w_next;
            r_grant       <= w_grant_nx;
            r_rd          <= w_rd_nx;
            r_tx_data     <= w_tx_data_nx;
            r_tx_datak    <= w_datak_nx;
            r_busy        <= (w_next != ST_IDLE);
            r_last_winner <= w_last_nx;
            r_len_cnt     <= w_len_nx;
        end
    end

    assign grant    = r_grant;
    assign rd       = r_rd;
    assign tx_data  = r_tx_data;
    assign tx_datak = r_tx_datak;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ol_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ol_tx_arbiter
//  Brief   : Directed self-checking bench for ol_tx_arbiter (NREQ=4).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ol_tx_arbiter;

    localparam int NREQ = 4;

    logic               clk;
    logic               rst_n;
    logic               link_ready;
    logic [NREQ-1:0]    req;
    logic [8*NREQ-1:0]  req_len;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    rd;
    logic [15:0]        tx_data;
    logic [1:0]         tx_datak;
    logic               busy;

    int n_checks;
    int n_fail;
    int rd_count;
    int ptr [NREQ];

    ol_tx_arbiter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_ready (link_ready),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .grant      (grant),
        .rd         (rd),
        .tx_data    (tx_data),
        .tx_datak   (tx_datak),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead requester sources: word n of requester 0 is 1111*(n+1).
    function automatic logic [15:0] data_of(input int i, input int n);
        logic [15:0] v;
        v = 16'((n + 1) * 16'h1111) ^ 16'(i << 12);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) ptr[i] <= 0;
            rd_count <= 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rd[i]) ptr[i] <= ptr[i] + 1;
            end
            rd_count <= rd_count + $countones(rd);
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*16 +: 16] = data_of(i, ptr[i]);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        link_ready = 1'b0;
        req        = '0;
        req_len    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] d, input logic [1:0] k);
        check_val(tag, {14'd0, tx_datak, tx_data}, {14'd0, k, d});
    endtask

    function automatic logic [15:0] hdr(input int src, input int len);
        logic [15:0] h;
        h = 16'hA000 | 16'(src << 8) | 16'(len);
        return h;
    endfunction

    function automatic logic [15:0] trailer(input logic [15:0] h, input logic [15:0] x);
`ifdef OL_TX_ARB_CHECKSUM_EN
        return h ^ x;
`else
        return 16'hFFFF;
`endif
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        link_ready = 1'b0;
        req        = '0;
        req_len    = '0;

        // Reset values
        @(negedge clk);
        check_val("rst_outputs", {grant, rd, busy, tx_datak, tx_data},
                  {4'b0000, 4'b0000, 1'b0, 2'b01, 16'h50BC});
        rst_n = 1'b1;

        // Basic packet: req0, two words
        link_ready = 1'b1;
        req        = 4'b0001;
        req_len[7:0] = 8'd2;
        tick();
        expect_word("pkt_hdr", 16'hA002, 2'b00);
        check_val("pkt_grant", {28'd0, grant}, 32'h1);
        check_val("pkt_busy", {31'd0, busy}, 32'h1);
        req          = 4'b0000;
        req_len[7:0] = 8'd9;
        tick();
        expect_word("pkt_w0", 16'h1111, 2'b00);
        tick();
        expect_word("pkt_w1", 16'h2222, 2'b00);
        tick();
        expect_word("pkt_trl", trailer(16'hA002, 16'h3333), 2'b00);
        tick();
        expect_word("pkt_idle", 16'h50BC, 2'b01);
        check_val("pkt_end", {27'd0, grant, busy}, 32'h0);
        check_val("pkt_rd_count", rd_count, 2);

        // Round-robin among four zero-length requesters
        do_reset();
        link_ready = 1'b1;
        req        = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            tick();
            check_val($sformatf("rr_grant%0d", p), {28'd0, grant}, 32'(1 << (p % 4)));
            expect_word($sformatf("rr_hdr%0d", p), hdr(p % 4, 0), 2'b00);
            tick();
            expect_word($sformatf("rr_trl%0d", p), trailer(hdr(p % 4, 0), 16'h0), 2'b00);
            tick();
            expect_word($sformatf("rr_idle%0d", p), 16'h50BC, 2'b01);
        end
        check_val("rr_no_rd", rd_count, 0);

        // Maximum length packet
        do_reset();
        link_ready   = 1'b1;
        req          = 4'b0001;
        req_len[7:0] = 8'd255;
        tick();
        req = 4'b0000;
        begin
            int cyc;
            cyc = 0;
            for (int t = 0; t < 400; t++) begin
                if (!busy) break;
                cyc++;
                tick();
            end
            check_val("max_busy_cycles", cyc, 257);
        end
        check_val("max_rd_count", rd_count, 255);
        expect_word("max_idle", 16'h50BC, 2'b01);

        // Link drop in the third payload cycle
        do_reset();
        link_ready   = 1'b1;
        req          = 4'b0001;
        req_len[7:0] = 8'd5;
        tick();
        req = 4'b0000;
        repeat (3) tick();
        expect_word("drop_p3", 16'h3333, 2'b00);
        link_ready = 1'b0;
        tick();
        expect_word("drop_idle", 16'h50BC, 2'b01);
        check_val("drop_ctl", {23'd0, grant, rd, busy}, 32'h0);
        req        = 4'b1111;
        req_len    = '0;
        link_ready = 1'b1;
        tick();
        check_val("drop_next_grant", {28'd0, grant}, 32'h2);

        // Asynchronous reset in the middle of a header
        do_reset();
        link_ready   = 1'b1;
        req          = 4'b0001;
        req_len[7:0] = 8'd3;
        tick();
        expect_word("arst_hdr", 16'hA003, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_outputs", {grant, rd, busy, tx_datak, tx_data},
                  {4'b0000, 4'b0000, 1'b0, 2'b01, 16'h50BC});
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester wins back to back
        do_reset();
        link_ready    = 1'b1;
        req           = 4'b0100;
        req_len[23:16] = 8'd1;
        tick();
        check_val("single_grant_a", {28'd0, grant}, 32'h4);
        repeat (3) tick();
        tick();
        check_val("single_grant_b", {28'd0, grant}, 32'h4);
        expect_word("single_hdr_b", hdr(2, 1), 2'b00);

        // Link down: nothing may start
        do_reset();
        link_ready = 1'b0;
        req        = 4'b1111;
        for (int t = 0; t < 100; t++) begin
            tick();
            check_val("linkdown", {grant, busy, tx_datak, tx_data},
                      {4'b0000, 1'b0, 2'b01, 16'h50BC});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
